// File: rtl/oled_pkg.sv
// Shared definitions for the OLED command engine.
//   oled_cmd_t   : 88-bit packed command word, byte 0 (opcode) in [87:80]
//   OP_*         : SSD1306-class opcodes that carry operand bytes (plus scroll on/off)
//   oled_state_e : sequencing states of oled_cmd_engine
//   cmd_len()    : total bytes (opcode + operands) to send for a given opcode
package oled_pkg;

  typedef logic [87:0] oled_cmd_t;

  localparam logic [7:0] OP_SET_MEM_MODE     = 8'h20;
  localparam logic [7:0] OP_SET_COL_ADDR     = 8'h21;
  localparam logic [7:0] OP_SET_PAGE_ADDR    = 8'h22;
  localparam logic [7:0] OP_HSCROLL_R        = 8'h26;
  localparam logic [7:0] OP_HSCROLL_L        = 8'h27;
  localparam logic [7:0] OP_VHSCROLL_R       = 8'h29;
  localparam logic [7:0] OP_VHSCROLL_L       = 8'h2A;
  localparam logic [7:0] OP_DEACT_SCROLL     = 8'h2E;
  localparam logic [7:0] OP_ACT_SCROLL       = 8'h2F;
  localparam logic [7:0] OP_SET_CONTRAST     = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP      = 8'h8D;
  localparam logic [7:0] OP_SET_VSCROLL_AREA = 8'hA3;
  localparam logic [7:0] OP_SET_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] OP_SET_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] OP_SET_CLK_DIV      = 8'hD5;
  localparam logic [7:0] OP_SET_PRECHARGE    = 8'hD9;
  localparam logic [7:0] OP_SET_COM_PINS     = 8'hDA;
  localparam logic [7:0] OP_SET_VCOMH        = 8'hDB;

  typedef enum logic [1:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold
  } oled_state_e;

  // Opcodes not listed are single-byte commands.
  function automatic logic [3:0] cmd_len(input logic [7:0] op);
    logic [3:0] len;
    case (op)
      OP_HSCROLL_R, OP_HSCROLL_L:                        len = 4'd7;
      OP_VHSCROLL_R, OP_VHSCROLL_L:                      len = 4'd6;
      OP_SET_VSCROLL_AREA:                               len = 4'd3;
      OP_SET_COL_ADDR, OP_SET_PAGE_ADDR:                 len = 4'd3;
      OP_SET_MEM_MODE, OP_SET_CONTRAST, OP_CHARGE_PUMP,
      OP_SET_MUX_RATIO, OP_SET_DISP_OFFSET, OP_SET_CLK_DIV,
      OP_SET_PRECHARGE, OP_SET_COM_PINS, OP_SET_VCOMH:   len = 4'd2;
      default:                                           len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/oled_cmd_engine_spi_byte_shifter.sv
// One-byte SPI mode-0 serializer with its own SCLK divider.
//   clk, rst : system clock, synchronous active-high reset
//   load     : start shifting byte_in (accepted when idle or in the done cycle)
//   byte_in  : byte to send, MSB first
//   sclk     : SPI clock, CLK_DIV cycles low then CLK_DIV cycles high per bit
//   sdo      : SPI data, changes only while sclk is (or is returning) low
//   done     : last cycle of bit 7's high phase; a load here chains the next byte
//              with no gap
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       sdo,
  output logic       done
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  logic       busy_q, busy_d;
  logic       sclk_q, sclk_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       tick;

  assign tick = busy_q && (div_q == DivLast);
  assign done = tick && sclk_q && (bit_q == 3'd7);

  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    div_d  = div_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    if (load) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      div_d  = 8'd0;
      bit_d  = 3'd0;
      sh_d   = byte_in;
    end else if (tick) begin
      div_d = 8'd0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        // Falling edge: next bit appears on sdo in the same cycle.
        sclk_d = 1'b0;
        if (bit_q == 3'd7) begin
          busy_d = 1'b0;
          sh_d   = 8'h00;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
        end
      end
    end else if (busy_q) begin
      div_d = div_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      div_q  <= 8'd0;
      bit_q  <= 3'd0;
      sh_q   <= 8'h00;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
    end
  end

  assign sclk = sclk_q;
  assign sdo  = sh_q[7];

endmodule

// File: rtl/oled_cmd_engine.sv
// Responder end of the draw/rdy command interface: latches a packed command,
// looks up its length from the opcode and sends that many bytes to the OLED
// over 4-wire SPI (command mode), framed by chip select.
//   clk, rst : system clock, synchronous active-high reset
//   draw     : command strobe, sampled only while rdy=1
//   oled_IR  : packed command, byte 0 (opcode) in [87:80]
//   rdy      : idle, ready to accept draw
//   sclk/sdo : SPI mode 0, MSB first
//   cs_n     : chip select, active-low, low for the whole non-idle period
//   dc       : data/command select, always 0
//   nbytes   : byte count of the current/last command
module oled_cmd_engine
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CMD_BYTES = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     draw,
  input  logic [8*CMD_BYTES-1:0]   oled_IR,
  output logic                     rdy,
  output logic                     sclk,
  output logic                     sdo,
  output logic                     cs_n,
  output logic                     dc,
  output logic [3:0]               nbytes
);

  localparam int unsigned CmdW    = 8 * CMD_BYTES;
  localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);

  oled_state_e state_q, state_d;
  logic [7:0]  guard_q, guard_d;
  oled_cmd_t   cmd_q, cmd_d;
  logic [3:0]  byte_q, byte_d;
  logic [3:0]  nbytes_q, nbytes_d;
  logic        dc_q;

  logic        sh_load;
  logic [7:0]  sh_byte;
  logic        sh_sclk;
  logic        sh_sdo;
  logic        sh_done;

  // cmd_q[CmdW-1 -: 8] always holds the byte currently on (or about to go on) the wire.
  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    cmd_d    = cmd_q;
    byte_d   = byte_q;
    nbytes_d = nbytes_q;
    sh_load  = 1'b0;
    sh_byte  = cmd_q[CmdW-1 -: 8];
    unique case (state_q)
      StIdle: begin
        if (draw) begin
          cmd_d    = oled_IR;
          nbytes_d = cmd_len(oled_IR[CmdW-1 -: 8]);
          byte_d   = 4'd0;
          guard_d  = 8'd0;
          state_d  = StCsSetup;
        end
      end
      StCsSetup: begin
        if (guard_q == DivLast) begin
          guard_d = 8'd0;
          sh_load = 1'b1;
          state_d = StShift;
        end else begin
          guard_d = guard_q + 8'd1;
        end
      end
      StShift: begin
        if (sh_done) begin
          if (byte_q == nbytes_q - 4'd1) begin
            guard_d = 8'd0;
            state_d = StCsHold;
          end else begin
            sh_load = 1'b1;
            sh_byte = cmd_q[CmdW-9 -: 8];
            cmd_d   = {cmd_q[CmdW-9:0], 8'h00};
            byte_d  = byte_q + 4'd1;
          end
        end
      end
      StCsHold: begin
        if (guard_q == DivLast) begin
          guard_d = 8'd0;
          state_d = StIdle;
        end else begin
          guard_d = guard_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      guard_q  <= 8'd0;
      cmd_q    <= '0;
      byte_q   <= 4'd0;
      nbytes_q <= 4'd0;
      dc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      cmd_q    <= cmd_d;
      byte_q   <= byte_d;
      nbytes_q <= nbytes_d;
      dc_q     <= 1'b0;
    end
  end

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .byte_in (sh_byte),
    .sclk    (sh_sclk),
    .sdo     (sh_sdo),
    .done    (sh_done)
  );

  // The shifter is not loaded until setup ends, so present the first bit directly.
  assign sdo    = (state_q == StCsSetup) ? cmd_q[CmdW-1] : sh_sdo;
  assign sclk   = sh_sclk;
  assign rdy    = (state_q == StIdle);
  assign cs_n   = (state_q == StIdle);
  assign dc     = dc_q;
  assign nbytes = nbytes_q;

endmodule

// File: tb/tb_oled_cmd_engine.sv
module tb_oled_cmd_engine;

  localparam int CLK_DIV = 4;
  localparam int LIMIT   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        draw;
  logic [87:0] oled_IR;
  logic        rdy, sclk, sdo, cs_n, dc;
  logic [3:0]  nbytes;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observations from the most recent transfer.
  int          low_cyc, cs_bad, dc_bad, nbits;
  bit          first_ok;
  logic        cs_at_end;
  logic [7:0]  got_q[$];

  always #5 clk = ~clk;

  oled_cmd_engine #(
    .CLK_DIV   (CLK_DIV),
    .CMD_BYTES (11)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .draw    (draw),
    .oled_IR (oled_IR),
    .rdy     (rdy),
    .sclk    (sclk),
    .sdo     (sdo),
    .cs_n    (cs_n),
    .dc      (dc),
    .nbytes  (nbytes)
  );

  // Reference length table.
  function automatic int ref_len(input logic [7:0] op);
    case (op)
      8'h26, 8'h27: return 7;
      8'h29, 8'h2A: return 6;
      8'hA3, 8'h21, 8'h22: return 3;
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [79:0] rand80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  // Issue cmd (call at a negedge with rdy=1) and record the wire activity until rdy returns.
  // busy_at>0 raises a stray draw for two cycles at that point of the transfer.
  task automatic run_xfer(input logic [87:0] cmd, input int busy_at, input bit hold);
    logic       prev;
    logic [7:0] acc;
    draw    = 1'b1;
    oled_IR = cmd;
    @(negedge clk);
    if (!hold) begin
      draw    = 1'b0;
      oled_IR = {$urandom(), $urandom(), 24'($urandom())};
    end
    first_ok = (sdo === cmd[87]) && (sclk === 1'b0) && (cs_n === 1'b0) && (rdy === 1'b0);
    low_cyc = 0; cs_bad = 0; dc_bad = 0; nbits = 0; got_q = {};
    prev = 1'b0; acc = 8'h00;
    while (rdy !== 1'b1 && low_cyc < LIMIT) begin
      low_cyc++;
      if (cs_n !== 1'b0) cs_bad++;
      if (dc !== 1'b0) dc_bad++;
      if (sclk === 1'b1 && prev === 1'b0) begin
        acc = {acc[6:0], sdo};
        nbits++;
        if (nbits % 8 == 0) got_q.push_back(acc);
      end
      prev = sclk;
      if (busy_at > 0 && low_cyc == busy_at) begin
        draw    = 1'b1;
        oled_IR = {8'h2E, rand80()};
      end
      if (busy_at > 0 && low_cyc == busy_at + 2) draw = 1'b0;
      @(negedge clk);
    end
    cs_at_end = cs_n;
  endtask

  task automatic test_reset();
    rst = 1'b1; draw = 1'b0; oled_IR = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rdy, cs_n, sclk, dc} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rdy/cs_n/sclk/dc got %b want 1100", {rdy, cs_n, sclk, dc});
    end
    tests_run++;
    if ({sdo, nbytes} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_data: sdo/nbytes got %b want 00000", {sdo, nbytes});
    end
  endtask

  task automatic test_scroll();
    logic [87:0] cmd = 88'h26_00_00_00_07_00_FF_00_00_00_00;
    run_xfer(cmd, 0, 1'b0);
    tests_run++;
    if (low_cyc != 456) begin
      tests_failed++; $display("FAIL scroll_rdy_low: got %0d want 456", low_cyc);
    end
    tests_run++;
    if (nbits != 56) begin
      tests_failed++; $display("FAIL scroll_edges: got %0d want 56", nbits);
    end
    for (int k = 0; k < 7; k++) begin
      tests_run++;
      if (k >= got_q.size() || got_q[k] !== cmd[87-8*k -: 8]) begin
        tests_failed++;
        $display("FAIL scroll_byte%0d: got %h want %h", k,
                 (k < got_q.size()) ? got_q[k] : 8'hxx, cmd[87-8*k -: 8]);
      end
    end
    tests_run++;
    if (cs_at_end !== 1'b1 || cs_bad != 0 || dc_bad != 0 || !first_ok) begin
      tests_failed++;
      $display("FAIL scroll_frame: cs_end %b cs_bad %0d dc_bad %0d first_ok %0b want 1 0 0 1",
               cs_at_end, cs_bad, dc_bad, first_ok);
    end
    tests_run++;
    if (nbytes !== 4'd7) begin
      tests_failed++; $display("FAIL scroll_nbytes: got %0d want 7", nbytes);
    end
  endtask

  task automatic test_single();
    run_xfer({8'h2F, 80'h0}, 0, 1'b0);
    tests_run++;
    if (low_cyc != CLK_DIV * 18 || nbits != 8) begin
      tests_failed++;
      $display("FAIL single_timing: low %0d edges %0d want %0d 8", low_cyc, nbits, CLK_DIV * 18);
    end
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 8'h2F) begin
      tests_failed++;
      $display("FAIL single_byte: got %h (n=%0d) want 2f", got_q.size() ? got_q[0] : 8'hxx,
               got_q.size());
    end
  endtask

  task automatic test_busy_draw();
    int stray = 0;
    run_xfer(88'h26_00_00_00_07_00_FF_00_00_00_00, 100, 1'b0);
    repeat (12) begin
      if (cs_n !== 1'b1 || rdy !== 1'b1) stray++;
      @(negedge clk);
    end
    tests_run++;
    if (nbits != 56 || low_cyc != 456 || stray != 0) begin
      tests_failed++;
      $display("FAIL busy_ignored: edges %0d low %0d stray %0d want 56 456 0", nbits, low_cyc,
               stray);
    end
    tests_run++;
    if (nbytes !== 4'd7) begin
      tests_failed++; $display("FAIL busy_nbytes: got %0d want 7", nbytes);
    end
  endtask

  task automatic test_back_to_back();
    logic [87:0] cmd = {8'h81, 8'h7F, 72'(rand80())};
    for (int pass = 0; pass < 2; pass++) begin
      run_xfer(cmd, 0, pass == 0);
      tests_run++;
      if (low_cyc != CLK_DIV * 34 || got_q.size() != 2 || got_q[0] !== 8'h81 ||
          got_q[1] !== 8'h7F) begin
        tests_failed++;
        $display("FAIL b2b_xfer%0d: low %0d bytes %p want %0d 81 7f", pass, low_cyc, got_q,
                 CLK_DIV * 34);
      end
      tests_run++;
      // Pass 0 ends on the single idle cycle; pass 1 must start right after it.
      if (cs_at_end !== 1'b1 || !first_ok) begin
        tests_failed++;
        $display("FAIL b2b_gap%0d: cs_end %b first_ok %0b want 1 1", pass, cs_at_end, first_ok);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   rises = 0, cyc = 0;
    logic prev  = 1'b0;
    logic [87:0] cmd;
    draw = 1'b1; oled_IR = {8'h26, rand80()};
    @(negedge clk);
    draw = 1'b0;
    while (rises < 13 && cyc < LIMIT) begin
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk; cyc++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rises != 13 || {cs_n, sclk, rdy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL rst_mid_abort: rises %0d cs_n/sclk/rdy %b want 13 101", rises,
               {cs_n, sclk, rdy});
    end
    rst = 1'b0;
    @(negedge clk);
    cmd = {8'h26, rand80()};
    run_xfer(cmd, 0, 1'b0);
    tests_run++;
    if (low_cyc != CLK_DIV * 114 || got_q.size() != 7 || got_q[0] !== 8'h26 ||
        got_q[6] !== cmd[39:32] || !first_ok) begin
      tests_failed++;
      $display("FAIL rst_mid_clean: low %0d bytes %p want %0d from %h", low_cyc, got_q,
               CLK_DIV * 114, cmd);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops[20] = '{8'h26, 8'h27, 8'h29, 8'h2A, 8'hA3, 8'h21, 8'h22, 8'h20, 8'h81,
                            8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h2E, 8'h2F,
                            8'hAF, 8'h00};
    for (int it = 0; it < 12; it++) begin
      logic [7:0]  op;
      logic [87:0] cmd;
      int          n, bad;
      op  = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : ops[$urandom_range(0, 19)];
      cmd = {op, rand80()};
      n   = ref_len(op);
      run_xfer(cmd, 0, 1'b0);
      bad = 0;
      for (int k = 0; k < n; k++)
        if (k >= got_q.size() || got_q[k] !== cmd[87-8*k -: 8]) bad++;
      tests_run++;
      if (low_cyc != CLK_DIV * (2 + 16 * n) || nbits != 8 * n || bad != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_xfer op %h: low %0d edges %0d badbytes %0d want %0d %0d 0",
                 it, op, low_cyc, nbits, bad, CLK_DIV * (2 + 16 * n), 8 * n);
      end
      tests_run++;
      if (nbytes !== 4'(n) || cs_at_end !== 1'b1 || cs_bad != 0 || dc_bad != 0 || !first_ok)
      begin
        tests_failed++;
        $display("FAIL rand%0d_frame op %h: nbytes %0d cs_end %b cs_bad %0d first_ok %0b",
                 it, op, nbytes, cs_at_end, cs_bad, first_ok);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_single();
    test_busy_draw();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/oled_cmd_engine.md
Name: oled_cmd_engine

Overview:
- Responder end of the draw/ready command interface of the instruction executor.
- On each accepted `draw`, latches the 88-bit packed command word `oled_IR` and looks up its byte count from the opcode in byte 0.
- Serializes that many bytes to the SSD1306-class OLED over 4-wire SPI in command mode (dc=0), then re-asserts `rdy`.

Parameters:
- CLK_DIV, 4, system cycles per SCLK half-period; legal range 1..255.
- CMD_BYTES, 11, width of `oled_IR` in bytes; fixed at 11 (88 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- draw  in  1  command strobe; sampled only while `rdy`=1
- oled_IR  in  88  packed command; byte 0 = [87:80] (opcode), byte k = [87-8k -: 8]
- rdy  out  1  engine idle; can accept `draw`
- sclk  out  1  SPI clock, mode 0 (idle low)
- sdo  out  1  SPI data, MSB first
- cs_n  out  1  OLED chip select, active-low
- dc  out  1  data/command select; always 0 for this block
- nbytes  out  4  byte count of the current/last command (debug/coverage)

Behaviour:
- Reset values:
  - rdy=1, sclk=0, sdo=0, cs_n=1, dc=0, nbytes=0.
  - State=IDLE; shift register and counters cleared.
- Reset mid-transfer aborts immediately: the next cycle shows cs_n=1, sclk=0, rdy=1. No partial byte is completed.
- Length lookup, N = cmd_len(oled_IR[87:80]):
  - 0x26, 0x27 → 7
  - 0x29, 0x2A → 6
  - 0xA3 → 3
  - 0x21, 0x22 → 3
  - 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB → 2
  - any other opcode → 1
- Accept: in IDLE, `draw`=1 at cycle T. Then:
  - oled_IR is latched into the shift register and nbytes=N.
  - At T+1: rdy=0, cs_n=0, sdo=oled_IR[87], sclk=0.
- `draw` while rdy=0 is ignored; it is neither queued nor counted. `oled_IR` changes while busy have no effect.
- States and transitions:
  - IDLE → CS_SETUP on accepted `draw`.
  - CS_SETUP: CLK_DIV cycles with sclk=0, then → SHIFT.
  - SHIFT, per bit:
    - CLK_DIV cycles with sclk=0 (sdo stable), then CLK_DIV cycles with sclk=1.
    - On the falling edge the next bit is driven: sdo changes in the same cycle sclk returns to 0.
  - After bit 8N: → CS_HOLD.
  - CS_HOLD: CLK_DIV cycles with sclk=0, cs_n=0, then → IDLE. cs_n=1 and rdy=1 in the same cycle.
- Bytes are sent contiguously; there is no inter-byte gap. Bytes beyond N are never shifted.
- rdy low duration is exactly CLK_DIV·(2 + 16N) cycles.
- Counters:
  - Divider counter: 8 bits, wraps at CLK_DIV-1.
  - Bit counter: 3 bits, wraps 7→0, incrementing the byte counter.
  - Byte counter: 4 bits, terminates at N-1 with bit=7. No counter overflow is possible because N≤11.
- The `draw` pulse width is irrelevant: a level held across the return to IDLE starts a new transfer in the first IDLE cycle.
- `dc` is tied low but registered, so it is driven as a constant 0 from reset.

Decomposition:
- Package oled_pkg:
  - typedef oled_cmd_t (logic[87:0]);
  - opcode localparams (OP_HSCROLL_R=8'h26, OP_HSCROLL_L=8'h27, OP_DEACT_SCROLL=8'h2E, OP_ACT_SCROLL=8'h2F, ...);
  - function cmd_len(logic[7:0]) returning logic[3:0];
  - state enum typedef.
- One sub-module, spi_byte_shifter:
  - Contains the divider plus the 8-bit MSB-first shift for one byte.
  - Handshake: `load`/`byte_in`/`done`.
  - oled_cmd_engine sequences bytes and chip select around it.

Test Plan:
- Reset check: assert rst for 3 cycles → rdy=1, cs_n=1, sclk=0, dc=0 the cycle after release.
- Scroll command, CLK_DIV=4: draw with oled_IR=88'h26_00_00_00_07_00_FF_00_00_00_00 →
  - rdy low exactly 456 cycles;
  - 56 sclk rising edges;
  - bytes sampled on rising edges = 26 00 00 00 07 00 FF;
  - cs_n high the same cycle rdy rises; nbytes=7.
- Single-byte command: draw with 88'h2F_00..00 →
  - 8 sclk edges, byte 0x2F sampled;
  - rdy low 4·(2+16)=72 cycles.
- Busy draw: issue a second draw with 88'h2E_.. mid-transfer of the scroll command → ignored; only 7 bytes sent, no second cs_n assertion.
- Back-to-back: draw held high through the end of the 0x81 command (operand 0x7F) →
  - exactly 1 idle cycle with cs_n=1;
  - a second transfer 81 7F starts.
- Reset mid-transfer: assert rst after bit 13 of a 0x26 command → next cycle cs_n=1, sclk=0, rdy=1; a subsequent draw transfers cleanly from bit 87.
